// File: rtl/alu_muldiv_ctrl_if.sv
// Bundle of ID/EX-side request signals and EX-side results for alu_muldiv_ctrl.
// The master drives the decoded instruction and operands; the slave is the control block.
interface alu_muldiv_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4
);
  logic                  start;
  logic [1:0]            ALUOp;
  logic [5:0]            funct;
  logic [DATA_WIDTH-1:0] src_a;
  logic [DATA_WIDTH-1:0] src_b;
  logic [CTRL_WIDTH-1:0] ALU_control_input;
  logic                  busy;
  logic                  done;
  logic                  stall;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output start, ALUOp, funct, src_a, src_b,
    input  ALU_control_input, busy, done, stall, hi, lo
  );

  modport slave (
    input  start, ALUOp, funct, src_a, src_b,
    output ALU_control_input, busy, done, stall, hi, lo
  );
endinterface

// File: rtl/alu_muldiv_ctrl.sv
// EX-stage ALU select decode plus iterative shift-add multiply / restoring divide with HI/LO.
// Optional macro MULDIV_EARLY_OUT_EN: multiply finishes once the remaining multiplier bits are zero.
module alu_muldiv_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4
) (
  input logic               clk,
  input logic               reset,
  alu_muldiv_ctrl_if.slave  bus
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  function automatic logic [W-1:0] f_cneg_w(input logic [W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*W-1:0] f_cneg_2w(input logic [2*W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic             r_is_div;
  logic             r_div0;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [W-1:0]     r_hi;
  logic [W-1:0]     r_lo;
  logic [2*W-1:0]   r_prod;
  logic [2*W-1:0]   r_mcand;
  logic [W-1:0]     r_mplier;

  logic [CTRL_WIDTH-1:0] w_alu_sel;
  logic             w_is_muldiv;
  logic             w_accept;
  logic             w_unsigned;
  logic             w_sa;
  logic             w_sb;
  logic             w_b_zero;
  logic [W-1:0]     w_a_mag;
  logic [W-1:0]     w_b_mag;
  logic             w_mul_last;
  logic [W:0]       w_shift;
  logic [W:0]       w_diff;
  logic [W-1:0]     w_rem_next;
  logic [W-1:0]     w_q_next;
  logic [2*W-1:0]   w_prod_fix;
  logic [W-1:0]     w_hi_fix;
  logic [W-1:0]     w_lo_fix;

  always_comb begin
    w_alu_sel = CTRL_WIDTH'(4'b1111);
    case (bus.ALUOp)
      2'b00: w_alu_sel = CTRL_WIDTH'(4'b0010);
      2'b01: w_alu_sel = CTRL_WIDTH'(4'b0110);
      2'b10: begin
        case (bus.funct)
          6'b100000: w_alu_sel = CTRL_WIDTH'(4'b0010);
          6'b100010: w_alu_sel = CTRL_WIDTH'(4'b0110);
          6'b100100: w_alu_sel = CTRL_WIDTH'(4'b0000);
          6'b100101: w_alu_sel = CTRL_WIDTH'(4'b0001);
          6'b101010: w_alu_sel = CTRL_WIDTH'(4'b0111);
          6'b100111: w_alu_sel = CTRL_WIDTH'(4'b1100);
          6'b000000: w_alu_sel = CTRL_WIDTH'(4'b1000);
          6'b000010: w_alu_sel = CTRL_WIDTH'(4'b1001);
          6'b000011: w_alu_sel = CTRL_WIDTH'(4'b1010);
          6'b010000: w_alu_sel = CTRL_WIDTH'(4'b1101);
          6'b010010: w_alu_sel = CTRL_WIDTH'(4'b1110);
          6'b011000, 6'b011001,
          6'b011010, 6'b011011: w_alu_sel = CTRL_WIDTH'(4'b0010);
          default:   w_alu_sel = CTRL_WIDTH'(4'b1111);
        endcase
      end
      default: w_alu_sel = CTRL_WIDTH'(4'b1111);
    endcase
  end

  // funct 0110xx: bit0 selects unsigned, bit1 selects divide
  assign w_is_muldiv = (bus.ALUOp == 2'b10) && (bus.funct[5:2] == 4'b0110);
  assign w_accept    = bus.start && w_is_muldiv;
  assign w_unsigned  = bus.funct[0];
  assign w_sa        = ~w_unsigned & bus.src_a[W-1];
  assign w_sb        = ~w_unsigned & bus.src_b[W-1];
  assign w_b_zero    = (bus.src_b == '0);
  assign w_a_mag     = f_cneg_w(bus.src_a, w_sa);
  assign w_b_mag     = f_cneg_w(bus.src_b, w_sb);

`ifdef MULDIV_EARLY_OUT_EN
  assign w_mul_last = (r_cnt == CW'(W-1)) || (r_mplier[W-1:1] == '0);
`else
  assign w_mul_last = (r_cnt == CW'(W-1));
`endif

  // Restoring divide step: remainder in r_prod upper half, quotient shifts in at the bottom
  assign w_shift    = {r_prod[2*W-1:W], r_prod[W-1]};
  assign w_diff     = w_shift - {1'b0, r_mcand[W-1:0]};
  assign w_rem_next = w_diff[W] ? w_shift[W-1:0] : w_diff[W-1:0];
  assign w_q_next   = {r_prod[W-2:0], ~w_diff[W]};

  always_comb begin
    w_prod_fix = f_cneg_2w(r_prod, r_neg_q);
    w_hi_fix   = w_prod_fix[2*W-1:W];
    w_lo_fix   = w_prod_fix[W-1:0];
    if (r_div0) begin
      w_hi_fix = r_prod[2*W-1:W];
      w_lo_fix = '1;
    end else if (r_is_div) begin
      w_hi_fix = f_cneg_w(r_prod[2*W-1:W], r_neg_r);
      w_lo_fix = f_cneg_w(r_prod[W-1:0], r_neg_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_is_div <= 1'b0;
      r_div0   <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt    <= '0;
            r_is_div <= bus.funct[1];
            r_div0   <= bus.funct[1] && w_b_zero;
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            if (bus.funct[1] && w_b_zero) r_state <= S_FIX;
            else if (bus.funct[1])        r_state <= S_DIV;
            else                          r_state <= S_MUL;
          end
        end
        S_MUL: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_mul_last) r_state <= S_FIX;
        end
        S_DIV: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(W-1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_hi    <= w_hi_fix;
          r_lo    <= w_lo_fix;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Working datapath registers carry no reset; control state decides when they matter
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (bus.funct[1] && w_b_zero) begin
            r_prod <= {bus.src_a, {W{1'b0}}};
          end else if (bus.funct[1]) begin
            r_prod  <= {{W{1'b0}}, w_a_mag};
            r_mcand <= {{W{1'b0}}, w_b_mag};
          end else begin
            r_prod   <= '0;
            r_mcand  <= {{W{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
          end
        end
      end
      S_MUL: begin
        if (r_mplier[0]) r_prod <= r_prod + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
      S_DIV: r_prod <= {w_rem_next, w_q_next};
      default: ;
    endcase
  end

  assign bus.ALU_control_input = w_alu_sel;
  assign bus.busy  = (r_state != S_IDLE);
  assign bus.done  = r_done;
  assign bus.stall = (r_state != S_IDLE) | w_accept;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Directed bench for alu_muldiv_ctrl: decode table, mul/div results, latency, stall and reset abort.
module tb_alu_muldiv_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int EXP_EARLY = 2;
`else
  localparam int EXP_EARLY = 33;
`endif

  alu_muldiv_ctrl_if #(.DATA_WIDTH(32), .CTRL_WIDTH(4)) bus ();

  alu_muldiv_ctrl #(.DATA_WIDTH(32), .CTRL_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one mul/div at edge 0; edges returns the edge after which done was seen
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int edges, output logic busy0);
    bus.ALUOp = 2'b10;
    bus.funct = f;
    bus.src_a = a;
    bus.src_b = b;
    bus.start = 1'b1;
    #1;
    chk("stall_on_request", {63'b0, bus.stall}, 64'd1);
    tick();
    bus.start = 1'b0;
    busy0 = bus.busy;
    edges = 0;
    while (bus.done !== 1'b1 && edges < 100) begin
      tick();
      edges++;
    end
  endtask

  task automatic check_pulse_end(input string tag);
    tick();
    chk({tag, "_done_clr"}, {63'b0, bus.done}, 64'd0);
    chk({tag, "_idle"},     {63'b0, bus.busy}, 64'd0);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [5:0] f;
    logic [3:0] exp;
  } dec_vec_t;

  dec_vec_t dec_tab [0:9];

  initial begin
    int   e;
    logic b0;
    int   done_seen;

    dec_tab[0] = '{2'b00, 6'b000000, 4'b0010};
    dec_tab[1] = '{2'b01, 6'b100000, 4'b0110};
    dec_tab[2] = '{2'b11, 6'b100000, 4'b1111};
    dec_tab[3] = '{2'b10, 6'b100010, 4'b0110};
    dec_tab[4] = '{2'b10, 6'b000011, 4'b1010};
    dec_tab[5] = '{2'b10, 6'b110000, 4'b1111};
    dec_tab[6] = '{2'b10, 6'b100100, 4'b0000};
    dec_tab[7] = '{2'b10, 6'b010000, 4'b1101};
    dec_tab[8] = '{2'b10, 6'b011011, 4'b0010};
    dec_tab[9] = '{2'b10, 6'b100111, 4'b1100};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.ALUOp = 2'b00;
    bus.funct = 6'b0;
    bus.src_a = '0;
    bus.src_b = '0;
    repeat (2) tick();
    chk("rst_busy",  {63'b0, bus.busy},  64'd0);
    chk("rst_done",  {63'b0, bus.done},  64'd0);
    chk("rst_stall", {63'b0, bus.stall}, 64'd0);
    chk("rst_hilo",  {bus.hi, bus.lo},   64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      bus.ALUOp = dec_tab[i].op;
      bus.funct = dec_tab[i].f;
      #1;
      chk($sformatf("decode_%0d", i), {60'b0, bus.ALU_control_input}, {60'b0, dec_tab[i].exp});
    end
    tick();

    // mult 7 * -3
    run_op(6'b011000, 32'd7, 32'hFFFF_FFFD, e, b0);
    chk("mult_busy0", {63'b0, b0}, 64'd1);
    chk("mult_lat",   64'(e), 64'd33);
    chk("mult_hilo",  {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mult_stall_done", {63'b0, bus.stall}, 64'd0);
    check_pulse_end("mult");

    run_op(6'b011011, 32'd100, 32'd7, e, b0);
    chk("divu_lat",  64'(e), 64'd33);
    chk("divu_hilo", {bus.hi, bus.lo}, 64'h0000_0002_0000_000E);
    check_pulse_end("divu");

    run_op(6'b011010, 32'hFFFF_FFF9, 32'd2, e, b0);
    chk("div_neg_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    check_pulse_end("div_neg");

    run_op(6'b011010, 32'd5, 32'd0, e, b0);
    chk("div0_busy0", {63'b0, b0}, 64'd1);
    chk("div0_lat",   64'(e), 64'd1);
    chk("div0_hilo",  {bus.hi, bus.lo}, 64'h0000_0005_FFFF_FFFF);
    check_pulse_end("div0");

    run_op(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, e, b0);
    chk("div_ovf_hilo", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
    check_pulse_end("div_ovf");

    run_op(6'b011000, 32'h8000_0000, 32'h8000_0000, e, b0);
    chk("mult_minmin", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);
    check_pulse_end("mult_minmin");

    run_op(6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e, b0);
    chk("multu_max", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    check_pulse_end("multu_max");

    // second start while busy must be ignored
    bus.ALUOp = 2'b10;
    bus.funct = 6'b011000;
    bus.src_a = 32'd3;
    bus.src_b = 32'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    e = 0;
    repeat (3) begin tick(); e++; end
    bus.funct = 6'b011001;
    bus.src_a = 32'd100;
    bus.src_b = 32'd100;
    bus.start = 1'b1;
    #1;
    chk("busy_stall", {63'b0, bus.stall}, 64'd1);
    tick();
    e++;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && e < 100) begin tick(); e++; end
    chk("ignore_lat",  64'(e), 64'd33);
    chk("ignore_hilo", {bus.hi, bus.lo}, 64'h0000_0000_0000_000F);
    check_pulse_end("ignore");

    // reset during a multiply
    bus.funct = 6'b011000;
    bus.src_a = 32'h0000_1234;
    bus.src_b = 32'h0000_5678;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    chk("midop_busy", {63'b0, bus.busy}, 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", {63'b0, bus.busy}, 64'd0);
    chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    tick();
    reset = 1'b0;
    done_seen = 0;
    repeat (40) begin
      tick();
      if (bus.done === 1'b1) done_seen++;
    end
    chk("abort_no_done", 64'(done_seen), 64'd0);
    chk("abort_hilo_kept", {bus.hi, bus.lo}, 64'd0);

    run_op(6'b011001, 32'd9, 32'd1, e, b0);
    chk("early_lat",  64'(e), 64'(EXP_EARLY));
    chk("early_hilo", {bus.hi, bus.lo}, 64'h0000_0000_0000_0009);
    check_pulse_end("early");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
